// File: rtl/phys_reg_free_list_pkg.sv
// Shared sizing for the physical register file, free list, reservation list and rename table.
package phys_reg_free_list_pkg;

  localparam int N_PHYS = 64;
  localparam int N_ARCH = 32;
  localparam int TAG_W  = 6;

  typedef logic [TAG_W-1:0] phys_tag_t;
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  typedef logic [TAG_W:0]   fl_ptr_t;

endpackage

// File: rtl/phys_reg_free_list_ptr_ctrl.sv
// Pointer control for the physical register free list: alloc, commit and tail pointers,
// occupancy, and the rewind restore of the speculative alloc pointer.
module fl_ptr_ctrl
  import phys_reg_free_list_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  logic      rewind,
  input  logic      allocate,
  input  logic      commitAlloc,
  input  logic      push,
  output phys_tag_t allocIdx,
  output phys_tag_t tailIdx,
  output fl_ptr_t   freeCount,
  output logic      allocValid,
  output logic      full
);

  fl_ptr_t allocPtr;
  fl_ptr_t commitPtr;
  fl_ptr_t tailPtr;
  fl_ptr_t commitNext;
  logic    commitOk;
  logic    doAlloc;

  assign freeCount  = tailPtr - allocPtr;
  assign allocValid = (freeCount != '0);
  // Full counts speculatively allocated slots as occupied until they commit
  assign full       = ((tailPtr - commitPtr) == fl_ptr_t'(N_PHYS));
  assign allocIdx   = allocPtr[TAG_W-1:0];
  assign tailIdx    = tailPtr[TAG_W-1:0];

  assign commitOk   = commitAlloc && (commitPtr != allocPtr);
  assign commitNext = commitPtr + fl_ptr_t'(commitOk);
  assign doAlloc    = allocate && allocValid && !rewind;

  always_ff @(posedge clk) begin
    if (reset) begin
      allocPtr  <= '0;
      commitPtr <= '0;
      tailPtr   <= fl_ptr_t'(N_PHYS - N_ARCH);
    end else if (en) begin
      commitPtr <= commitNext;
      // Rewind lands on the committed point including any same-cycle commit
      if (rewind)
        allocPtr <= commitNext;
      else if (doAlloc)
        allocPtr <= allocPtr + fl_ptr_t'(1);
      if (push)
        tailPtr <= tailPtr + fl_ptr_t'(1);
    end
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: hands tags to rename, takes them back from commit.
// The release strobe is called releaseReq because "release" is a reserved word.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  logic      rewind,
  input  logic      allocate,
  input  logic      commitAlloc,
  input  logic      releaseReq,
  input  phys_tag_t releaseTag,
  output logic      allocValid,
  output phys_tag_t allocTag,
  output fl_ptr_t   freeCount,
  output logic      overflowErr
);

  phys_tag_t mem [N_PHYS];
  phys_tag_t allocIdx;
  phys_tag_t tailIdx;
  logic      full;
  logic      badRelease;
  logic      push;

  // Tag 0 stays permanently mapped, so it is refused like a release into a full list
  assign badRelease = releaseReq && ((releaseTag == '0) || full);
  assign push       = en && releaseReq && !badRelease;

  fl_ptr_ctrl u_ptr (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .rewind      (rewind),
    .allocate    (allocate),
    .commitAlloc (commitAlloc),
    .push        (push),
    .allocIdx    (allocIdx),
    .tailIdx     (tailIdx),
    .freeCount   (freeCount),
    .allocValid  (allocValid),
    .full        (full)
  );

  assign allocTag = mem[allocIdx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_PHYS; i++)
        mem[i] <= (i < N_PHYS - N_ARCH) ? phys_tag_t'(N_ARCH + i) : '0;
    end else if (push) begin
      mem[tailIdx] <= releaseTag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      overflowErr <= 1'b0;
    else if (en && badRelease)
      overflowErr <= 1'b1;
  end

endmodule
